alu_exec_stage: RTL

//  Execute pipeline stage wrapped around the 32-bit combinational ALU. Accepts decoded

---
 rtl/cpu_pkg.sv | 19 +
 rtl/alu.sv | 25 ++
 rtl/result_fifo.sv | 73 +++++++
 rtl/alu_exec_stage.sv | 89 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU opcode encodings and opcode helpers.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Shift amounts use the full B operand; callers mask as needed.
module alu
  import cpu_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_SLL: y = a << b;
      OP_SRL: y = a >> b;
      OP_AND: y = a & b;
      OP_SRA: y = $signed(a) >>> b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/result_fifo.sv
// Small FIFO for tagged results with a registered head that holds its value when empty.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DW-1:0]              head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DW-1:0]   head_q, head_d;
  logic            full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign head    = head_q;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    head_d  = head_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The pushed entry becomes head when it lands exactly at the new read pointer.
    if (count_d != '0) begin
      head_d = (do_push && (rptr_d == wptr_q)) ? push_data : mem_q[rptr_d];
    end
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      head_d  = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (do_push) mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand forwarding/masking around the ALU, buffered tagged results to writeback.
module alu_exec_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic             in_fwd_a,
  input  logic             in_fwd_b,
  input  logic [REG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [REG_W-1:0] out_rd,
  output logic [31:0]      retired
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [CntW-1:0]       count;
  logic                  empty;
  logic                  accept, pop;
  logic [XLEN-1:0]       opa, opb, alu_b, alu_y;
  logic [XLEN-1:0]       last_result_q;
  logic                  last_valid_q;
  logic [31:0]           retired_q;
  logic [XLEN+REG_W-1:0] head;

  // in_ready depends on registered occupancy only, so writeback cannot reach upstream.
  assign in_ready  = (count < CntW'(DEPTH));
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign opa   = (in_fwd_a & last_valid_q) ? last_result_q : in_a;
  assign opb   = (in_fwd_b & last_valid_q) ? last_result_q : in_b;
  assign alu_b = is_shift(in_op) ? {{(XLEN-5){1'b0}}, opb[4:0]} : opb;

  alu u_alu (
    .op (in_op),
    .a  (opa),
    .b  (alu_b),
    .y  (alu_y)
  );

  result_fifo #(
    .DEPTH (DEPTH),
    .DW    (XLEN + REG_W)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept & ~flush),
    .push_data ({alu_y, in_rd}),
    .pop       (pop),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  assign out_result = head[XLEN+REG_W-1:REG_W];
  assign out_rd     = head[REG_W-1:0];
  assign retired    = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_result_q <= '0;
      last_valid_q  <= 1'b0;
      retired_q     <= '0;
    end else begin
      if (pop) retired_q <= retired_q + 32'd1;
      if (flush) begin
        last_valid_q <= 1'b0;
      end else if (accept) begin
        last_valid_q  <= 1'b1;
        last_result_q <= alu_y;
      end
    end
  end

endmodule
